// File: rtl/reg_file_pkg.sv
// Shared pipeline package: register-file geometry and the operand/address types that
// the ID/EX, EX/MEM and MEM/WB stages reuse.
package reg_file_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    // x0 is hardwired to zero; writes to it are dropped and reads return 0.
    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_file_if.sv
// Write-back and operand-read bundle between the pipeline (master) and the register
// file (slave).
interface reg_file_if;
    import reg_file_pkg::*;

    logic      reg_write_i;
    reg_addr_t reg_write_data_addr_i;
    xlen_t     reg_write_data_i;
    reg_addr_t rs1_addr_i;
    reg_addr_t rs2_addr_i;
    xlen_t     rs1_data_o;
    xlen_t     rs2_data_o;

    modport master (
        output reg_write_i,
        output reg_write_data_addr_i,
        output reg_write_data_i,
        output rs1_addr_i,
        output rs2_addr_i,
        input  rs1_data_o,
        input  rs2_data_o
    );

    modport slave (
        input  reg_write_i,
        input  reg_write_data_addr_i,
        input  reg_write_data_i,
        input  rs1_addr_i,
        input  rs2_addr_i,
        output rs1_data_o,
        output rs2_data_o
    );

endinterface

// File: rtl/reg_read_port.sv
// One combinational register read port: x0 returns zero, an in-flight write-back to the
// same index is bypassed, otherwise the stored value is returned.
module reg_read_port
    import reg_file_pkg::*;
(
    input  logic      i_rst,
    input  logic      i_wr_en,
    input  reg_addr_t i_wr_addr,
    input  xlen_t     i_wr_data,
    input  reg_addr_t i_rd_addr,
    input  xlen_t     i_stored,
    output xlen_t     o_rd_data
);

    // Priority: zero register, then bypass (suppressed while reset discards the write),
    // then the array.
    always_comb begin
        o_rd_data = i_stored;
        if (i_rd_addr == ZERO_REG) begin
            o_rd_data = '0;
        end else if (!i_rst && i_wr_en && (i_wr_addr == i_rd_addr)) begin
            o_rd_data = i_wr_data;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32 x XLEN integer register file: one write-back per clock, two combinational read
// ports with same-cycle write-to-read bypass. x0 has no storage.
module reg_file
    import reg_file_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  rf
);

    xlen_t r_regs [1:NREG-1];
    xlen_t w_rs1_stored;
    xlen_t w_rs2_stored;

    // Commit the write-back; reset clears every register and wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (rf.reg_write_i && (rf.reg_write_data_addr_i != ZERO_REG)) begin
            r_regs[rf.reg_write_data_addr_i] <= rf.reg_write_data_i;
        end
    end

    // Array lookups; index 0 has no storage so it is steered away from the array.
    always_comb begin
        w_rs1_stored = '0;
        w_rs2_stored = '0;
        if (rf.rs1_addr_i != ZERO_REG) begin
            w_rs1_stored = r_regs[rf.rs1_addr_i];
        end
        if (rf.rs2_addr_i != ZERO_REG) begin
            w_rs2_stored = r_regs[rf.rs2_addr_i];
        end
    end

    reg_read_port u_rs1_port (
        .i_rst     (rst),
        .i_wr_en   (rf.reg_write_i),
        .i_wr_addr (rf.reg_write_data_addr_i),
        .i_wr_data (rf.reg_write_data_i),
        .i_rd_addr (rf.rs1_addr_i),
        .i_stored  (w_rs1_stored),
        .o_rd_data (rf.rs1_data_o)
    );

    reg_read_port u_rs2_port (
        .i_rst     (rst),
        .i_wr_en   (rf.reg_write_i),
        .i_wr_addr (rf.reg_write_data_addr_i),
        .i_wr_data (rf.reg_write_data_i),
        .i_rd_addr (rf.rs2_addr_i),
        .i_stored  (w_rs2_stored),
        .o_rd_data (rf.rs2_data_o)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic compared
// against an array-based architectural model.
module tb_reg_file;

    logic clk;
    logic rst;

    reg_file_if rf ();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Architectural state: m_regs[0] is never used; x0 reads are zero by rule.
    logic [31:0] m_regs [32];
    logic [31:0] e1;
    logic [31:0] e2;

    // What the spec says port n must show for address a given the inputs now driven.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (!rst && rf.reg_write_i && rf.reg_write_data_addr_i == a) return rf.reg_write_data_i;
        return m_regs[a];
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2, input logic r);
        rf.reg_write_i           = we;
        rf.reg_write_data_addr_i = wa;
        rf.reg_write_data_i      = wd;
        rf.rs1_addr_i            = a1;
        rf.rs2_addr_i            = a2;
        rst                      = r;
        #2;
    endtask

    // Apply the clock edge to the model, then to the DUT.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (rf.reg_write_i && rf.reg_write_data_addr_i != 5'd0) begin
            m_regs[rf.reg_write_data_addr_i] = rf.reg_write_data_i;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        tick();
        // Second reset cycle: storage already cleared, outputs must be zero.
        drive(1'b1, 5'd4, 32'hCAFE0001, 5'd4, 5'd4, 1'b1);
        checks++;
        if (rf.rs1_data_o !== 32'd0 || rf.rs2_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold rs1=%h rs2=%h expected 0", rf.rs1_data_o, rf.rs2_data_o);
        end
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0);
            checks++;
            if (rf.rs1_data_o !== 32'd0 || rf.rs2_data_o !== 32'd0) begin
                errors++;
                $display("FAIL reset_read idx=%0d rs1=%h rs2=%h expected 0", i,
                         rf.rs1_data_o, rf.rs2_data_o);
            end
        end
    endtask

    task automatic test_basic_write();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd4, 5'd6, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd4, 1'b0);
        checks++;
        if (rf.rs1_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_x5 got=%h expected=deadbeef", rf.rs1_data_o);
        end
        checks++;
        if (rf.rs2_data_o !== 32'd0) begin
            errors++;
            $display("FAIL neighbour_x4 got=%h expected=0", rf.rs2_data_o);
        end
        drive(1'b0, 5'd0, 32'd0, 5'd6, 5'd5, 1'b0);
        checks++;
        if (rf.rs1_data_o !== 32'd0 || rf.rs2_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL neighbour_x6 rs1=%h rs2=%h expected 0/deadbeef",
                     rf.rs1_data_o, rf.rs2_data_o);
        end
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
        checks++;
        if (rf.rs1_data_o !== 32'd0 || rf.rs2_data_o !== 32'd0) begin
            errors++;
            $display("FAIL x0_same_cycle rs1=%h rs2=%h expected 0", rf.rs1_data_o, rf.rs2_data_o);
        end
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        checks++;
        if (rf.rs1_data_o !== 32'd0 || rf.rs2_data_o !== 32'd0) begin
            errors++;
            $display("FAIL x0_next_cycle rs1=%h rs2=%h expected 0", rf.rs1_data_o, rf.rs2_data_o);
        end
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 1'b0);
            checks++;
            if (rf.rs1_data_o !== m_regs[i] || rf.rs2_data_o !== m_regs[i]) begin
                errors++;
                $display("FAIL x0_no_side_effect idx=%0d got=%h expected=%h", i,
                         rf.rs1_data_o, m_regs[i]);
            end
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b0);
        checks++;
        if (rf.rs1_data_o !== 32'h12345678 || rf.rs2_data_o !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_same_cycle rs1=%h rs2=%h expected 12345678",
                     rf.rs1_data_o, rf.rs2_data_o);
        end
        tick();
        drive(1'b0, 5'd7, 32'h0BADF00D, 5'd7, 5'd7, 1'b0);
        checks++;
        if (rf.rs1_data_o !== 32'h12345678 || rf.rs2_data_o !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_committed rs1=%h rs2=%h expected 12345678",
                     rf.rs1_data_o, rf.rs2_data_o);
        end
    endtask

    task automatic test_no_write();
        drive(1'b1, 5'd9, 32'h00C0FFEE, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 5'd9, 32'hAAAA5555, 5'd9, 5'd0, 1'b0);
        checks++;
        if (rf.rs1_data_o !== 32'h00C0FFEE) begin
            errors++;
            $display("FAIL no_write_bypass got=%h expected=00c0ffee", rf.rs1_data_o);
        end
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0);
        checks++;
        if (rf.rs1_data_o !== 32'h00C0FFEE || rf.rs2_data_o !== 32'h00C0FFEE) begin
            errors++;
            $display("FAIL no_write_commit got=%h expected=00c0ffee", rf.rs1_data_o);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 1'b0);
            tick();
        end
        drive(1'b1, 5'd3, 32'h77, 5'd3, 5'd3, 1'b1);
        checks++;
        if (rf.rs1_data_o !== 32'd3 || rf.rs2_data_o !== 32'd3) begin
            errors++;
            $display("FAIL reset_no_bypass rs1=%h rs2=%h expected 3", rf.rs1_data_o, rf.rs2_data_o);
        end
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 1'b0);
            checks++;
            if (rf.rs1_data_o !== 32'd0 || rf.rs2_data_o !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid_clear idx=%0d rs1=%h rs2=%h expected 0", i,
                         rf.rs1_data_o, rf.rs2_data_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [4];
        want[0] = 32'd1;
        want[1] = 32'd2;
        want[2] = 32'd3;
        want[3] = 32'd3;
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, 5'd10, 32'(i + 1), 5'd0, 5'd10, 1'b0);
            checks++;
            if (rf.rs2_data_o !== want[i]) begin
                errors++;
                $display("FAIL back_to_back cycle=%0d got=%h expected=%h", i,
                         rf.rs2_data_o, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 40) == 0));
            // Steer reads toward the write target to exercise the bypass often.
            if ($urandom_range(0, 3) == 0) begin
                rf.rs1_addr_i = rf.reg_write_data_addr_i;
                #1;
            end
            e1 = model_read(rf.rs1_addr_i);
            e2 = model_read(rf.rs2_addr_i);
            checks++;
            if (rf.rs1_data_o !== e1 || rf.rs2_data_o !== e2) begin
                errors++;
                $display("FAIL random n=%0d a1=%0d a2=%0d rs1=%h/%h rs2=%h/%h", n,
                         rf.rs1_addr_i, rf.rs2_addr_i, rf.rs1_data_o, e1, rf.rs2_data_o, e2);
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        @(posedge clk);
        #1;
        test_reset();
        test_basic_write();
        test_x0();
        test_bypass();
        test_no_write();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
